// File: rtl/gyro_spi_reader.sv
// gyro_spi_reader: SPI mode-3 master that writes CTRL_REG1 once, then periodically burst-reads X/Y/Z rates.
module gyro_spi_reader #(
  parameter int         CLK_DIV       = 2,
  parameter int         SAMPLE_PERIOD = 100,
  parameter logic [7:0] CTRL1_VAL     = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic [15:0] angular_rate_x,
  output logic [15:0] angular_rate_y,
  output logic [15:0] angular_rate_z,
  output logic        sample_valid,
  output logic        init_done
);
  typedef enum logic [1:0] {INIT, XFER, GAP} state_t;
  state_t      state_q, state_d;
  logic        sclk_q, sclk_d, cs_n_q, cs_n_d, rd_q, rd_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [47:0] sin_q, sin_d;
  logic [55:0] sout_q, sout_d;
  logic        start, tick;
  assign start = state_q == INIT || (state_q == GAP && gap_cnt_q == 16'(SAMPLE_PERIOD));
  assign tick  = div_cnt_q == 8'(CLK_DIV - 1);
  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    rd_d      = rd_q;
    valid_d   = 1'b0;
    done_d    = done_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    sin_d     = sin_q;
    sout_d    = sout_q;
    if (start) begin
      state_d   = XFER;
      cs_n_d    = 1'b0;
      sclk_d    = 1'b1;
      div_cnt_d = 8'd0;
      rd_d      = state_q == GAP;
      bit_cnt_d = rd_d ? 6'd56 : 6'd16;
      sout_d    = rd_d ? {8'hE8, 48'd0} : {8'h20, CTRL1_VAL, 40'd0};
    end else if (state_q == GAP) begin
      gap_cnt_d = gap_cnt_q + 16'd1;
    end else if (state_q == XFER) begin
      div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
      if (tick && !sclk_q) begin
        sclk_d    = 1'b1;
        bit_cnt_d = bit_cnt_q - 6'd1;
        sin_d     = {sin_q[46:0], miso};
      end else if (tick && bit_cnt_q == 6'd0) begin
        state_d   = GAP;
        cs_n_d    = 1'b1;
        sout_d    = 56'd0;
        gap_cnt_d = 16'd0;
        valid_d   = rd_q;
        done_d    = 1'b1;
        x_d       = rd_q ? {sin_q[39:32], sin_q[47:40]} : x_q;
        y_d       = rd_q ? {sin_q[23:16], sin_q[31:24]} : y_q;
        z_d       = rd_q ? {sin_q[7:0], sin_q[15:8]} : z_q;
      end else if (tick) begin
        sclk_d = 1'b0;
        // the first falling edge only ends the lead-in; the MSB is already on mosi
        sout_d = (bit_cnt_q != (rd_q ? 6'd56 : 6'd16)) ? sout_q << 1 : sout_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      rd_q      <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= 6'd0;
      div_cnt_q <= 8'd0;
      gap_cnt_q <= 16'd0;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      z_q       <= 16'd0;
      sin_q     <= 48'd0;
      sout_q    <= 56'd0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      sin_q     <= sin_d;
      sout_q    <= sout_d;
    end
  end
  assign sclk           = sclk_q;
  assign cs_n           = cs_n_q;
  assign mosi           = sout_q[55];
  assign angular_rate_x = x_q;
  assign angular_rate_y = y_q;
  assign angular_rate_z = z_q;
  assign sample_valid   = valid_q;
  assign init_done      = done_q;
endmodule
